// File: rtl/intersection_scheduler_if.sv
// Signal bundle between the phase scheduler and its environment.
// Handshake: there is no valid/ready pair. req_y and emg_req are levels, and
// ped_req is a pulse of any length. All three are sampled on every rising clk
// edge. The lamp outputs and phase are valid on every cycle. They decode the
// scheduler's registered state only.
interface intersection_scheduler_if;
    logic       req_y;
    logic       ped_req;
    logic       emg_req;
    logic       Gx;
    logic       Rx;
    logic       Gy;
    logic       Ry;
    logic       ped_walk;
    logic [2:0] phase;

    modport master (
        output req_y, ped_req, emg_req,
        input  Gx, Rx, Gy, Ry, ped_walk, phase
    );

    modport slave (
        input  req_y, ped_req, emg_req,
        output Gx, Rx, Gy, Ry, ped_walk, phase
    );
endinterface

// File: rtl/intersection_scheduler.sv
// Actuated two-road phase scheduler (X = main road, Y = side road).
// Time is measured in ticks of TICK_DIV clocks. pc is the prescaler. tcnt counts
// the ticks completed in the current state. Both counters clear whenever the
// state changes. The phase output exposes the FSM state directly.
module intersection_scheduler #(
    parameter int TICK_DIV   = 10,
    parameter int X_MIN      = 250,
    parameter int Y_MIN      = 100,
    parameter int Y_MAX      = 150,
    parameter int PED_T      = 120,
    parameter int FLASH_T    = 50,
    parameter int FLASH_HALF = 5,
    parameter int ALLRED_T   = 20
) (
    input  logic                      clk,
    input  logic                      rst_n,
    intersection_scheduler_if.slave   bus
);

    typedef enum logic [2:0] {
        XG   = 3'd0,
        XF   = 3'd1,
        ARXY = 3'd2,
        YG   = 3'd3,
        YF   = 3'd4,
        ARYX = 3'd5,
        PRE  = 3'd6
    } state_t;

    localparam int TW = 16;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    // Thresholds are widened to n's width so that every comparison is unsigned and width-matched.
    localparam logic [TW:0]   X_MIN_N    = (TW+1)'(X_MIN);
    localparam logic [TW:0]   Y_MIN_N    = (TW+1)'(Y_MIN);
    localparam logic [TW:0]   Y_WALK_N   = (TW+1)'((PED_T > Y_MIN) ? PED_T : Y_MIN);
    localparam logic [TW:0]   Y_MAX_N    = (TW+1)'(Y_MAX);
    localparam logic [TW:0]   FLASH_N    = (TW+1)'(FLASH_T);
    localparam logic [TW:0]   ALLRED_N   = (TW+1)'(ALLRED_T);
    localparam logic [TW-1:0] FH         = TW'(FLASH_HALF);
    localparam logic [PW-1:0] PC_LAST    = PW'(TICK_DIV - 1);

    state_t        state;
    logic [PW-1:0] pc;
    logic [TW-1:0] tcnt;
    logic          y_pend;
    logic          ped_pend;
    logic          walk;

    logic          tick;
    logic [TW:0]   n;
    logic          exit_now;
    state_t        next_state;
    logic          enter_yg;
    logic          flash_on;

    // Tick-gated exit decision for the current state, using n = tcnt + 1.
    always_comb begin
        tick       = (pc == PC_LAST);
        n          = {1'b0, tcnt} + (TW+1)'(1);
        exit_now   = 1'b0;
        next_state = state;
        case (state)
            XG: if (n >= X_MIN_N &&
                    (y_pend || ped_pend || bus.req_y || bus.ped_req)) begin
                exit_now   = 1'b1;
                next_state = XF;
            end
            XF: if (n == FLASH_N) begin
                exit_now   = 1'b1;
                next_state = ARXY;
            end
            ARXY: if (n == ALLRED_N) begin
                exit_now   = 1'b1;
                next_state = YG;
            end
            YG: if (n == Y_MAX_N ||
                    (n >= (walk ? Y_WALK_N : Y_MIN_N) && !bus.req_y)) begin
                exit_now   = 1'b1;
                next_state = YF;
            end
            YF: if (n == FLASH_N) begin
                exit_now   = 1'b1;
                next_state = ARYX;
            end
            ARYX: if (n == ALLRED_N) begin
                exit_now   = 1'b1;
                next_state = XG;
            end
            default: ;
        endcase
        // Pre-emption wins over a tick exit on the same cycle. In that case YG is not entered.
        enter_yg = tick && exit_now && (next_state == YG) && !bus.emg_req;
    end

    // FSM, prescaler, tick counter and demand latches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ARYX;
            pc       <= '0;
            tcnt     <= '0;
            y_pend   <= 1'b0;
            ped_pend <= 1'b0;
            walk     <= 1'b0;
        end else begin
            // Requests that arrive on the cycle YG is entered are consumed by that entry.
            if (enter_yg) begin
                y_pend   <= 1'b0;
                ped_pend <= 1'b0;
                walk     <= ped_pend | bus.ped_req;
            end else begin
                y_pend   <= y_pend | bus.req_y;
                ped_pend <= ped_pend | bus.ped_req;
            end

            if (bus.emg_req && state != PRE) begin
                state <= PRE;
                pc    <= '0;
                tcnt  <= '0;
            end else if (state == PRE) begin
                // Leaving PRE always passes through a full ARYX before X gets green again.
                if (!bus.emg_req) state <= ARYX;
                pc   <= '0;
                tcnt <= '0;
            end else if (tick) begin
                pc <= '0;
                if (exit_now) begin
                    state <= next_state;
                    tcnt  <= '0;
                end else if (tcnt != '1) begin
                    // Saturate so that a long rest in XG cannot wrap below X_MIN.
                    tcnt <= tcnt + TW'(1);
                end
            end else begin
                pc <= pc + PW'(1);
            end
        end
    end

    // Lamp decode from the registered state. A flash starts with the green off.
    always_comb begin
        flash_on     = ((tcnt / FH) & TW'(1)) != '0;
        bus.Gx       = 1'b0;
        bus.Rx       = 1'b0;
        bus.Gy       = 1'b0;
        bus.Ry       = 1'b0;
        bus.phase    = state;
        bus.ped_walk = walk && (state == YG);
        case (state)
            XG: begin
                bus.Gx = 1'b1;
                bus.Ry = 1'b1;
            end
            XF: begin
                bus.Gx = flash_on;
                bus.Ry = 1'b1;
            end
            YG: begin
                bus.Gy = 1'b1;
                bus.Rx = 1'b1;
            end
            YF: begin
                bus.Gy = flash_on;
                bus.Rx = 1'b1;
            end
            default: begin
                bus.Rx = 1'b1;
                bus.Ry = 1'b1;
            end
        endcase
    end

endmodule
